mem_access_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/rr_pick.sv | 43 ++++
 rtl/mem_access_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_access_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the table-memory arbiter: FSM encoding, drain length,
// default memory geometry and the one-hot to index helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_t;

    localparam int DRAIN_CYCLES = 2;
    localparam int DEFAULT_AW   = 11;
    localparam int DEFAULT_DW   = 16;
    localparam int MAX_NREQ     = 8;

    // Index of the highest set bit; callers only pass one-hot or zero vectors.
    function automatic logic [2:0] onehot_to_idx(input logic [MAX_NREQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_NREQ; i++) begin
            if (oh[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping, reported both one-hot and as an index.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [IW-1:0]   win_idx,
    output logic            any
);

    logic                found;
    int                  pos;
    logic [MAX_NREQ-1:0] oh_ext;

    // Scan from the pointer upward and keep only the first hit.
    always_comb begin
        win_oh = '0;
        found  = 1'b0;
        pos    = 0;
        for (int i = 0; i < NREQ; i++) begin
            pos = (int'(ptr) + i) % NREQ;
            if (!found && req[pos]) begin
                win_oh[pos] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    // Widen the winner to the helper's fixed width before converting.
    always_comb begin
        oh_ext             = '0;
        oh_ext[NREQ-1:0]   = win_oh;
    end

    assign win_idx = IW'(onehot_to_idx(oh_ext));
    assign any     = |req;

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter in front of the single-port routing/aggregation table
// RAM. One engine owns the memory at a time; its strobes are registered onto
// the RAM port and read data returns tagged to the engine that issued it.
// Optional hold limit with forced revoke: define ARB_TIMEOUT_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no owner; pick a winner from the pending requests
// ST_GRANT | owner w holds gnt[w]; its strobes pass to the RAM each cycle
// ST_DRAIN | post-release gap so no new grant overlaps an outstanding read
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int AW       = DEFAULT_AW,
    parameter int DW       = DEFAULT_DW,
    parameter int MAX_HOLD = 15
) (
    input  logic              clock,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ-1:0]   req_wr_en,
    input  logic [NREQ-1:0]   req_rd_en,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rd_valid,
    output logic [DW-1:0]     rd_data,
    output logic [AW-1:0]     mem_address,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [DW-1:0]     mem_data_out,
    input  logic [DW-1:0]     mem_data_in,
    output logic              timeout_err
);

    localparam int IW = $clog2(NREQ);
    localparam int DCW = 2;

    if (NREQ < 2 || NREQ > MAX_NREQ || MAX_HOLD < 1) begin : g_bad_param
        $error("mem_access_arbiter: NREQ must be 2..8 and MAX_HOLD >= 1");
    end

    arb_state_t       state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [DCW-1:0]   drain_q, drain_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic             wr_q, wr_d;
    logic             rd_q, rd_d;
    logic [IW-1:0]    rd_tag_q, rd_tag_d;
    logic [NREQ-1:0]  rd_valid_q, rd_valid_d;

    logic [NREQ-1:0]  elig;
    logic [NREQ-1:0]  pick_oh;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;

    logic             cur_req;
    logic             cur_wr;
    logic             cur_rd;
    logic [AW-1:0]    cur_addr;
    logic [DW-1:0]    cur_wdata;
    logic [IW-1:0]    next_ptr;

`ifdef ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0]    hold_q, hold_d;
    logic [NREQ-1:0]  blocked_q, blocked_d;
    logic             timeout_q, timeout_d;

    // A revoked engine stays out of arbitration until it drops req once.
    assign elig = req & ~blocked_q;
`else
    assign elig = req;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req     (elig),
        .ptr     (ptr_q),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    assign cur_req   = req[owner_q];
    assign cur_wr    = req_wr_en[owner_q];
    assign cur_rd    = req_rd_en[owner_q];
    assign cur_addr  = req_addr[owner_q*AW +: AW];
    assign cur_wdata = req_wdata[owner_q*DW +: DW];
    assign next_ptr  = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

    // Next-state and next-output decode for the grant FSM and RAM port.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        gnt_d      = gnt_q;
        drain_d    = drain_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = 1'b0;
        rd_d       = 1'b0;
        rd_tag_d   = rd_tag_q;
        rd_valid_d = rd_q ? (NREQ'(1) << rd_tag_q) : '0;
`ifdef ARB_TIMEOUT_EN
        hold_d     = hold_q;
        blocked_d  = blocked_q & req;
        timeout_d  = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_oh;
                    owner_d = pick_idx;
                    state_d = ST_GRANT;
`ifdef ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            ST_GRANT: begin
                if (!cur_req) begin
                    gnt_d   = '0;
                    ptr_d   = next_ptr;
                    drain_d = DCW'(DRAIN_CYCLES - 1);
                    state_d = ST_DRAIN;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_q == HW'(MAX_HOLD - 1)) begin
                    gnt_d              = '0;
                    ptr_d              = next_ptr;
                    drain_d            = DCW'(DRAIN_CYCLES - 1);
                    state_d            = ST_DRAIN;
                    timeout_d          = 1'b1;
                    blocked_d[owner_q] = 1'b1;
                end
`endif
                else begin
                    addr_d   = cur_addr;
                    wdata_d  = cur_wdata;
                    wr_d     = cur_wr;
                    rd_d     = cur_rd & ~cur_wr;
                    rd_tag_d = owner_q;
`ifdef ARB_TIMEOUT_EN
                    hold_d   = hold_q + 1'b1;
`endif
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and output registers; reset also discards any in-flight read.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            gnt_q      <= '0;
            drain_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            rd_tag_q   <= '0;
            rd_valid_q <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_q     <= '0;
            blocked_q  <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            gnt_q      <= gnt_d;
            drain_q    <= drain_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            rd_tag_q   <= rd_tag_d;
            rd_valid_q <= rd_valid_d;
`ifdef ARB_TIMEOUT_EN
            hold_q     <= hold_d;
            blocked_q  <= blocked_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign gnt          = gnt_q;
    assign rd_valid     = rd_valid_q;
    // RAM data lands the cycle after mem_rd_en, which is when rd_valid is up.
    assign rd_data      = (|rd_valid_q) ? mem_data_in : '0;
    assign mem_address  = addr_q;
    assign mem_wr_en    = wr_q;
    assign mem_rd_en    = rd_q;
    assign mem_data_out = wdata_q;
`ifdef ARB_TIMEOUT_EN
    assign timeout_err  = timeout_q;
`else
    assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a behavioural table RAM.
module tb_mem_access_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 11;
    localparam int DW   = 16;

    logic              clock = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]   req_wr_en;
    logic [NREQ-1:0]   req_rd_en;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rd_valid;
    logic [DW-1:0]     rd_data;
    logic [AW-1:0]     mem_address;
    logic              mem_wr_en;
    logic              mem_rd_en;
    logic [DW-1:0]     mem_data_out;
    logic [DW-1:0]     mem_data_in;
    logic              timeout_err;

    logic [DW-1:0]     mem_model [0:(1<<AW)-1];

    int n_checks = 0;
    int n_errors = 0;
    int gap;
    int w;

    mem_access_arbiter #(
        .NREQ     (NREQ),
        .AW       (AW),
        .DW       (DW),
        .MAX_HOLD (15)
    ) dut (
        .clock        (clock),
        .rst          (rst),
        .req          (req),
        .req_addr     (req_addr),
        .req_wr_en    (req_wr_en),
        .req_rd_en    (req_rd_en),
        .req_wdata    (req_wdata),
        .gnt          (gnt),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .mem_address  (mem_address),
        .mem_wr_en    (mem_wr_en),
        .mem_rd_en    (mem_rd_en),
        .mem_data_out (mem_data_out),
        .mem_data_in  (mem_data_in),
        .timeout_err  (timeout_err)
    );

    always #5 clock = ~clock;

    // Synchronous RAM: one-cycle read latency.
    always @(posedge clock) begin
        if (mem_wr_en) mem_model[mem_address] <= mem_data_out;
        if (mem_rd_en) mem_data_in <= mem_model[mem_address];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_acc(input int i, input logic wr, input logic rd,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_wr_en[i]            = wr;
        req_rd_en[i]            = rd;
        req_addr[i*AW +: AW]    = a;
        req_wdata[i*DW +: DW]   = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem_model[i] = '0;
        mem_model[5]  = 16'hAAAA;
        mem_model[3]  = 16'h1234;
        mem_data_in   = '0;
        rst       = 1'b1;
        req       = '0;
        req_addr  = '0;
        req_wr_en = '0;
        req_rd_en = '0;
        req_wdata = '0;
        tick();
        tick();

        check("rst_gnt",      32'(gnt), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data",  32'(rd_data), 32'd0);
        check("rst_mem_addr", 32'(mem_address), 32'd0);
        check("rst_mem_wr",   32'(mem_wr_en), 32'd0);
        check("rst_mem_rd",   32'(mem_rd_en), 32'd0);
        check("rst_mem_dout", 32'(mem_data_out), 32'd0);
        check("rst_timeout",  32'(timeout_err), 32'd0);

        // Reset in the middle of a read.
        rst    = 1'b0;
        req[1] = 1'b1;
        tick();
        check("mr_gnt", 32'(gnt), 32'h2);
        set_acc(1, 1'b0, 1'b1, 11'h005, 16'h0);
        tick();
        check("mr_mem_rd", 32'(mem_rd_en), 32'd1);
        check("mr_addr",   32'(mem_address), 32'h005);
        rst = 1'b1;
        tick();
        check("mr_rd_valid", 32'(rd_valid), 32'd0);
        check("mr_rd_data",  32'(rd_data), 32'd0);
        check("mr_gnt_rst",  32'(gnt), 32'd0);
        check("mr_mem_rd0",  32'(mem_rd_en), 32'd0);
        check("mr_addr0",    32'(mem_address), 32'd0);
        rst = 1'b0;
        set_acc(1, 1'b0, 1'b0, 11'h0, 16'h0);
        req = 4'b0011;
        tick();
        check("mr_no_late_valid", 32'(rd_valid), 32'd0);
        check("mr_next_winner",   32'(gnt), 32'h1);
        req = '0;
        repeat (3) tick();

        // Single requester write; pointer is now 1, requester 2 wins.
        req[2] = 1'b1;
        tick();
        check("wr_gnt", 32'(gnt), 32'h4);
        set_acc(2, 1'b1, 1'b0, 11'h010, 16'hBEEF);
        tick();
        check("wr_addr",  32'(mem_address), 32'h010);
        check("wr_en",    32'(mem_wr_en), 32'd1);
        check("wr_rd_en", 32'(mem_rd_en), 32'd0);
        check("wr_data",  32'(mem_data_out), 32'hBEEF);
        req[2] = 1'b0;
        set_acc(2, 1'b0, 1'b0, 11'h0, 16'h0);
        req[0] = 1'b1;
        tick();
        check("wr_release_gnt", 32'(gnt), 32'd0);
        check("wr_release_wr",  32'(mem_wr_en), 32'd0);
        tick();
        check("wr_drain1_gnt", 32'(gnt), 32'd0);
        tick();
        check("wr_drain2_gnt", 32'(gnt), 32'd0);
        tick();
        check("wr_next_gnt", 32'(gnt), 32'h1);
        check("wr_mem_model", 32'(mem_model[16]), 32'hBEEF);
        req[0] = 1'b0;
        repeat (3) tick();

        // Read tag delivered after the owner has released; pointer is 1.
        req[1] = 1'b1;
        tick();
        check("rt_gnt", 32'(gnt), 32'h2);
        set_acc(1, 1'b0, 1'b1, 11'h003, 16'h0);
        tick();
        check("rt_mem_rd", 32'(mem_rd_en), 32'd1);
        check("rt_early_valid", 32'(rd_valid), 32'd0);
        req[1] = 1'b0;
        set_acc(1, 1'b0, 1'b0, 11'h0, 16'h0);
        tick();
        check("rt_gnt_low", 32'(gnt), 32'd0);
        check("rt_rd_valid", 32'(rd_valid), 32'h2);
        check("rt_rd_data", 32'(rd_data), 32'h1234);
        tick();
        check("rt_valid_pulse", 32'(rd_valid), 32'd0);
        tick();

        // Both strobes together: write wins; pointer is 2.
        req[2] = 1'b1;
        tick();
        check("bs_gnt", 32'(gnt), 32'h4);
        set_acc(2, 1'b1, 1'b1, 11'h020, 16'h5555);
        tick();
        check("bs_wr", 32'(mem_wr_en), 32'd1);
        check("bs_rd", 32'(mem_rd_en), 32'd0);
        req[2] = 1'b0;
        set_acc(2, 1'b0, 1'b0, 11'h0, 16'h0);
        tick();
        check("bs_no_valid1", 32'(rd_valid), 32'd0);
        tick();
        check("bs_no_valid2", 32'(rd_valid), 32'd0);
        tick();

        // Fairness from pointer 0 with all engines requesting.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            w   = g % NREQ;
            gap = 0;
            do begin
                tick();
                gap++;
            end while (gnt == '0 && gap < 10);
            check("fair_gap", 32'(gap), (g == 0) ? 32'd1 : 32'd3);
            check("fair_gnt", 32'(gnt), 32'(1) << w);
            set_acc(w, 1'b1, 1'b0, 11'(12'h040 + w), 16'(w));
            tick();
            set_acc(w, 1'b0, 1'b0, 11'h0, 16'h0);
            req[w] = 1'b0;
            tick();
            req[w] = 1'b1;
        end
        req = '0;
        repeat (4) tick();

`ifdef ARB_TIMEOUT_EN
        // Hold limit: requester 0 never releases.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1001;
        tick();
        check("to_gnt0", 32'(gnt), 32'h1);
        repeat (14) tick();
        check("to_still_held", 32'(gnt), 32'h1);
        check("to_no_err_yet", 32'(timeout_err), 32'd0);
        tick();
        check("to_revoke_gnt", 32'(gnt), 32'd0);
        check("to_err", 32'(timeout_err), 32'd1);
        tick();
        check("to_err_pulse", 32'(timeout_err), 32'd0);
        tick();
        tick();
        check("to_next_gnt", 32'(gnt), 32'h8);
        req = '0;
        repeat (4) tick();
`else
        check("tie_timeout", 32'(timeout_err), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
